instruction_fetch_unit: RTL and testbench
=========================================

Name: instruction_fetch_unit

Overview:
- Initiator side of the instruction-memory read interface.
- Owns the word-indexed PC and drives the fetch address to the combinational instruction memory.
- Captures each returned instruction word, with its PC, into a small FIFO.
- Hands instructions to decode over a valid/ready handshake; supports branch redirect with flush and an out-of-range fetch fault.

Parameters:
- IMEM_DEPTH, 128, number of 32-bit words in instruction memory; valid fetch addresses are 0..IMEM_DEPTH-1.
- FIFO_DEPTH, 2, fetch buffer entries; power of two, minimum 2.
- RESET_PC, 0, word index fetched first after reset.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_addr  out  32  word index presented to instruction memory; equals PC.
- imem_instr  in  32  combinational read data for imem_addr, valid in the same cycle.
- inst_valid  out  1  FIFO head holds an instruction.
- inst_ready  in  1  decode accepts the head this cycle.
- inst_data  out  32  instruction at the FIFO head.
- inst_pc  out  32  word index of inst_data.
- redirect_valid  in  1  branch/jump taken; flush and refetch.
- redirect_pc  in  32  new word index.
- fetch_fault  out  1  sticky; PC reached IMEM_DEPTH or beyond.

Behaviour:
- Reset: pc=RESET_PC, FIFO empty, inst_valid=0, inst_data=0, inst_pc=0, fetch_fault=0. Reset asserted mid-operation discards all buffered entries on that edge.
- imem_addr = pc, combinationally, every cycle.
- pop = inst_valid & inst_ready.
- push = !redirect_valid & !fetch_fault & (pc < IMEM_DEPTH) & (count < FIFO_DEPTH | pop).
- On push: write {imem_instr, pc} at the tail; pc <= pc+1 (32-bit wrap, unreachable in practice because of the fault).
- Latency:
  - Instruction at address A is visible on inst_data the cycle after pc==A, if the FIFO was not full.
  - Steady-state throughput is 1 instruction/cycle with inst_ready held high.
- Full FIFO with no pop: no push; pc holds.
- Full FIFO with pop in the same cycle: push and pop both occur; count unchanged.
- Empty FIFO: inst_valid=0; inst_data/inst_pc hold their last values (don't-care to decode).
- Redirect has priority over everything:
  - On the edge, FIFO count <= 0 and pc <= redirect_pc; fetch_fault <= 0.
  - No push that cycle.
  - A pop in the same cycle completes (decode has already accepted it); all other entries are dropped.
  - The first post-redirect instruction appears one cycle later.
- Out-of-range fault:
  - When pc >= IMEM_DEPTH and no redirect, fetch_fault <= 1 on that edge.
  - Pushes stop; already-buffered entries still drain normally.
  - Fault clears only on redirect or reset.
- Internal state: FIFO uses head/tail pointers of clog2(FIFO_DEPTH) bits plus a count of clog2(FIFO_DEPTH)+1 bits.

Optional Feature:
- Macro: IFU_PERF_CNT_EN.
- With the macro defined, three extra outputs are present:
  - perf_fetched (32): increments on each push.
  - perf_flushed (32): on each redirect, adds the number of dropped entries (count minus pop).
  - perf_stall (32): increments each cycle with no push while fetch_fault=0.
- All three counters reset to 0 and wrap at 2^32.
- Without the macro, these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package mips_pkg:
  - WORD_W=32.
  - IMEM_DEPTH default.
  - fetch_entry_t typedef {instr[31:0], pc[31:0]}.
  - Opcode/funct constants (R-type 000000, beq 000100, add 100000, sub 100010) for bench decoding.
- One natural sub-module: fetch_fifo.
  - Parameterised by depth and entry type.
  - Ports: push, pop, flush, full, empty, count, head entry.
  - Top level keeps the PC, fault and redirect logic.

Test Plan:
- Reset, then inst_ready=1 for 8 cycles, memory preloaded with words 0..7 -> inst_pc sequence 0,1,...,7 on consecutive cycles; first inst_valid one cycle after reset release; inst_data matches memory words.
- inst_ready=0 for 5 cycles from reset -> count saturates at 2, imem_addr holds at 2, then inst_ready=1 -> inst_pc 0,1,2,3 with no gap or duplicate.
- redirect_valid=1, redirect_pc=6 while the FIFO holds pc 3 and 4, inst_ready=1 -> pc 3 is accepted; next inst_valid is one cycle later with inst_pc=6; pc 4 never appears.
- redirect_pc=126 with IMEM_DEPTH=128 -> instructions 126 and 127 are delivered; fetch_fault=1 when pc=128; no further pushes; redirect to 0 clears the fault and restarts fetch.
- Reset asserted for 1 cycle while the FIFO is full -> inst_valid=0 the next cycle; first instruction after release has inst_pc=RESET_PC.
- IFU_PERF_CNT_EN defined; 10 fetches, then a redirect dropping 2 entries -> perf_fetched=10, perf_flushed=2.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared fetch-side types and constants: word width, default imem size, the buffered fetch entry
// and the MIPS opcode/funct encodings used when decoding fetched words.
package mips_pkg;

    localparam int WORD_W         = 32;
    localparam int IMEM_DEPTH_DEF = 128;

    typedef struct packed {
        logic [WORD_W-1:0] instr;
        logic [WORD_W-1:0] pc;
    } fetch_entry_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;

endpackage

// File: rtl/fetch_fifo.sv
// Power-of-two circular buffer of fetch entries; head entry read combinationally.
// Flush empties the buffer on the same edge, but a concurrent pop still retires its head entry.
module fetch_fifo
    import mips_pkg::*;
#(
    parameter int  DEPTH   = 2,
    parameter type entry_t = fetch_entry_t
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  entry_t                 wr_entry,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output entry_t                 head_entry
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    entry_t        mem [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW-1:0] head_nxt;

    assign head_nxt   = pop ? head + 1'b1 : head;
    assign full       = (count == CW'(DEPTH));
    assign empty      = (count == '0);
    assign head_entry = mem[head];

    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            // Collapse tail onto the post-pop head so the buffer restarts empty
            head  <= head_nxt;
            tail  <= head_nxt;
            count <= '0;
        end else begin
            head <= head_nxt;
            if (push) begin
                mem[tail] <= wr_entry;
                tail      <= tail + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// PC, redirect and out-of-range fault control around a small fetch buffer feeding decode.
// Optional performance counters (fetched/flushed/stall) are built when IFU_PERF_CNT_EN is defined.
module instruction_fetch_unit
    import mips_pkg::*;
#(
    parameter int          IMEM_DEPTH = IMEM_DEPTH_DEF,
    parameter int          FIFO_DEPTH = 2,
    parameter logic [31:0] RESET_PC   = '0
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
`ifdef IFU_PERF_CNT_EN
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_flushed,
    output logic [31:0] perf_stall,
`endif
    output logic        fetch_fault
);

    localparam int          CW      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [31:0] IMEM_TOP = 32'(IMEM_DEPTH);

    logic [31:0]   pc;
    logic          push;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    fetch_entry_t  wr_entry;
    fetch_entry_t  head_entry;

    assign imem_addr  = pc;
    assign inst_valid = !fifo_empty;
    assign inst_data  = head_entry.instr;
    assign inst_pc    = head_entry.pc;
    assign pop        = inst_valid && inst_ready;
    assign push       = !redirect_valid && !fetch_fault && (pc < IMEM_TOP) && (!fifo_full || pop);
    assign wr_entry   = '{instr: imem_instr, pc: pc};

    fetch_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (fetch_entry_t)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .pop        (pop),
        .flush      (redirect_valid),
        .wr_entry   (wr_entry),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (fifo_count),
        .head_entry (head_entry)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= RESET_PC;
            fetch_fault <= 1'b0;
        end else if (redirect_valid) begin
            pc          <= redirect_pc;
            fetch_fault <= 1'b0;
        end else begin
            if (push) pc <= pc + 32'd1;
            if (pc >= IMEM_TOP) fetch_fault <= 1'b1;
        end
    end

`ifdef IFU_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetched <= '0;
            perf_flushed <= '0;
            perf_stall   <= '0;
        end else begin
            if (push) perf_fetched <= perf_fetched + 32'd1;
            // Entries dropped by a redirect exclude the one decode takes on the same edge
            if (redirect_valid) perf_flushed <= perf_flushed + 32'(fifo_count - CW'(pop));
            if (!push && !fetch_fault) perf_stall <= perf_stall + 32'd1;
        end
    end
`else
    logic unused_count;
    assign unused_count = ^fifo_count;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: streaming, backpressure, redirect, range fault, reset flush.
module tb_instruction_fetch_unit;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fetch_fault;
`ifdef IFU_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_flushed;
    logic [31:0] perf_stall;
`endif

    int checks = 0;
    int errors = 0;

    logic [31:0] imem [128];

    always #5 clk = ~clk;

    instruction_fetch_unit #(
        .IMEM_DEPTH (128),
        .FIFO_DEPTH (2),
        .RESET_PC   (32'd0)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
`ifdef IFU_PERF_CNT_EN
        .perf_fetched   (perf_fetched),
        .perf_flushed   (perf_flushed),
        .perf_stall     (perf_stall),
`endif
        .fetch_fault    (fetch_fault)
    );

    always_comb begin
        imem_instr = 32'hFFFF_FFFF;
        if (imem_addr < 32'd128) imem_instr = imem[imem_addr[6:0]];
    end

    // Unique word per address: add / sub / beq in rotation, address in bits 22:16
    function automatic logic [31:0] word(input int i);
        logic [5:0] op;
        logic [5:0] fn;
        op = (i % 3 == 2) ? OP_BEQ : OP_RTYPE;
        fn = (i % 3 == 0) ? FN_ADD : ((i % 3 == 1) ? FN_SUB : 6'd0);
        return {op, 3'b000, 7'(i), 10'h2A5, fn};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset          = 1'b1;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        step();
        step();
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", inst_valid); end
        checks++; if (inst_data !== 32'd0) begin errors++; $display("FAIL reset_data got %h exp 0", inst_data); end
        checks++; if (inst_pc !== 32'd0) begin errors++; $display("FAIL reset_pc got %0d exp 0", inst_pc); end
        checks++; if (fetch_fault !== 1'b0) begin errors++; $display("FAIL reset_fault got %b exp 0", fetch_fault); end
        checks++; if (imem_addr !== 32'd0) begin errors++; $display("FAIL reset_addr got %0d exp 0", imem_addr); end
        reset = 1'b0;
        step();
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'd0) begin
            errors++; $display("FAIL first_fetch got valid %b pc %0d exp 1 0", inst_valid, inst_pc);
        end
    endtask

    task automatic test_stream();
        do_reset();
        inst_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'(k) || inst_data !== word(k)) begin
                errors++; $display("FAIL stream_%0d got v%b pc %0d d %h exp v1 pc %0d d %h",
                                   k, inst_valid, inst_pc, inst_data, k, word(k));
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int k = 0; k < 5; k++) step();
        checks++; if (imem_addr !== 32'd2) begin errors++; $display("FAIL bp_addr_hold got %0d exp 2", imem_addr); end
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'd0) begin
            errors++; $display("FAIL bp_head got v%b pc %0d exp v1 pc 0", inst_valid, inst_pc);
        end
        inst_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'(k) || inst_data !== word(k)) begin
                errors++; $display("FAIL bp_drain_%0d got v%b pc %0d exp v1 pc %0d", k, inst_valid, inst_pc, k);
            end
            step();
        end
    endtask

    task automatic test_redirect();
        do_reset();
        for (int k = 0; k < 3; k++) step();
        inst_ready = 1'b1;
        for (int k = 0; k < 3; k++) step();
        checks++; if (inst_pc !== 32'd3 || imem_addr !== 32'd5) begin
            errors++; $display("FAIL redir_setup got pc %0d addr %0d exp 3 5", inst_pc, imem_addr);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'd6;
        step();
        redirect_valid = 1'b0;
        checks++; if (inst_valid !== 1'b0 || imem_addr !== 32'd6) begin
            errors++; $display("FAIL redir_gap got v%b addr %0d exp v0 addr 6", inst_valid, imem_addr);
        end
        step();
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'd6 || inst_data !== word(6)) begin
            errors++; $display("FAIL redir_target got v%b pc %0d exp v1 pc 6", inst_valid, inst_pc);
        end
        step();
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'd7) begin
            errors++; $display("FAIL redir_next got v%b pc %0d exp v1 pc 7", inst_valid, inst_pc);
        end
    endtask

    task automatic test_fault();
        do_reset();
        inst_ready     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'd126;
        step();
        redirect_valid = 1'b0;
        step();
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'd126 || inst_data !== word(126)) begin
            errors++; $display("FAIL fault_126 got v%b pc %0d exp v1 pc 126", inst_valid, inst_pc);
        end
        step();
        checks++; if (inst_pc !== 32'd127 || fetch_fault !== 1'b0 || imem_addr !== 32'd128) begin
            errors++; $display("FAIL fault_127 got pc %0d f%b addr %0d exp 127 0 128", inst_pc, fetch_fault, imem_addr);
        end
        step();
        checks++; if (fetch_fault !== 1'b1 || inst_valid !== 1'b0) begin
            errors++; $display("FAIL fault_set got f%b v%b exp f1 v0", fetch_fault, inst_valid);
        end
        step();
        step();
        checks++; if (fetch_fault !== 1'b1 || inst_valid !== 1'b0 || imem_addr !== 32'd128) begin
            errors++; $display("FAIL fault_sticky got f%b v%b addr %0d exp f1 v0 128", fetch_fault, inst_valid, imem_addr);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'd0;
        step();
        redirect_valid = 1'b0;
        checks++; if (fetch_fault !== 1'b0) begin errors++; $display("FAIL fault_clear got %b exp 0", fetch_fault); end
        step();
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'd0 || inst_data !== word(0)) begin
            errors++; $display("FAIL fault_restart got v%b pc %0d exp v1 pc 0", inst_valid, inst_pc);
        end
    endtask

    task automatic test_reset_full();
        do_reset();
        for (int k = 0; k < 3; k++) step();
        checks++; if (inst_valid !== 1'b1 || imem_addr !== 32'd2) begin
            errors++; $display("FAIL rst_full_setup got v%b addr %0d exp v1 addr 2", inst_valid, imem_addr);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++; if (inst_valid !== 1'b0 || imem_addr !== 32'd0) begin
            errors++; $display("FAIL rst_full_flush got v%b addr %0d exp v0 addr 0", inst_valid, imem_addr);
        end
        inst_ready = 1'b1;
        step();
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'd0) begin
            errors++; $display("FAIL rst_full_restart got v%b pc %0d exp v1 pc 0", inst_valid, inst_pc);
        end
    endtask

`ifdef IFU_PERF_CNT_EN
    task automatic test_perf();
        do_reset();
        step();
        step();
        inst_ready = 1'b1;
        for (int k = 0; k < 8; k++) step();
        checks++; if (perf_fetched !== 32'd10) begin errors++; $display("FAIL perf_fetched got %0d exp 10", perf_fetched); end
        inst_ready     = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'd0;
        step();
        redirect_valid = 1'b0;
        checks++; if (perf_flushed !== 32'd2) begin errors++; $display("FAIL perf_flushed got %0d exp 2", perf_flushed); end
        checks++; if (perf_fetched !== 32'd10) begin errors++; $display("FAIL perf_fetched_hold got %0d exp 10", perf_fetched); end
        checks++; if (perf_stall !== 32'd1) begin errors++; $display("FAIL perf_stall got %0d exp 1", perf_stall); end
    endtask
`endif

    initial begin
        for (int i = 0; i < 128; i++) imem[i] = word(i);
        reset          = 1'b1;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_fault();
        test_reset_full();
`ifdef IFU_PERF_CNT_EN
        test_perf();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
